// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its LSU result FIFO.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_THROTTLE = 1'b1
    } starve_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries; pushes while full and pops while empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output entry_t                       head_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset: contents are only observable through a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority merge of ALU and LSU results onto one registered write port.
// Define WB_FWD_EN to add the write-to-read forwarding comparators and ports.
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [4:0]        lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef WB_FWD_EN
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data,
`endif
    output logic              lsu_pending
);

    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } entry_t;

    logic              alu_fire, lsu_fire, blocked, direct;
    logic              fifo_full, fifo_empty, push, pop, issue;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            fifo_head, issue_e;

    starve_state_e     state_q;
    logic [SC_W-1:0]   starve_cnt_q;
    logic              alu_rdy_q;

    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    assign alu_ready   = alu_rdy_q;
    assign lsu_ready   = rst_n & (fifo_count < CNT_W'(DEPTH));
    assign alu_fire    = alu_valid & alu_ready;
    assign lsu_fire    = lsu_valid & lsu_ready;
    assign blocked     = alu_fire & ~fifo_empty;
    assign direct      = lsu_fire & ~alu_fire & fifo_empty;
    assign push        = lsu_fire & ~direct & ~fifo_full;
    assign lsu_pending = ~fifo_empty;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (entry_t'{rd: lsu_rd, data: lsu_data}),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    // Issue priority: ALU, then FIFO head, then an LSU result bypassing an empty FIFO.
    always_comb begin
        issue   = 1'b0;
        pop     = 1'b0;
        issue_e = '0;
        if (alu_fire) begin
            issue   = 1'b1;
            issue_e = entry_t'{rd: alu_rd, data: alu_data};
        end else if (!fifo_empty) begin
            issue   = 1'b1;
            pop     = 1'b1;
            issue_e = fifo_head;
        end else if (lsu_fire) begin
            issue   = 1'b1;
            issue_e = entry_t'{rd: lsu_rd, data: lsu_data};
        end
    end

    // Writes to r0 consume the slot but leave the visible address/data untouched.
    always_comb begin
        wr_en_d   = issue & (issue_e.rd != REG_ZERO);
        wr_addr_d = wr_en_d ? issue_e.rd   : wr_addr_q;
        wr_data_d = wr_en_d ? issue_e.data : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // After STARVE_MAX consecutive blocked cycles, hold off the ALU for one cycle so the head pops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
            alu_rdy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (blocked) begin
                        if (starve_cnt_q == SC_W'(STARVE_MAX - 1)) begin
                            state_q      <= ST_THROTTLE;
                            starve_cnt_q <= '0;
                            alu_rdy_q    <= 1'b0;
                        end else begin
                            starve_cnt_q <= starve_cnt_q + SC_W'(1);
                        end
                    end else begin
                        starve_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_NORMAL;
                    starve_cnt_q <= '0;
                    alu_rdy_q    <= 1'b1;
                end
            endcase
        end
    end

`ifdef WB_FWD_EN
    assign fwd1_hit  = wr_en_q & (wr_addr_q == rs1_addr) & (rs1_addr != REG_ZERO);
    assign fwd2_hit  = wr_en_q & (wr_addr_q == rs2_addr) & (rs2_addr != REG_ZERO);
    assign fwd1_data = wr_data_q;
    assign fwd2_data = wr_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter (DEPTH=2, STARVE_MAX=4, default build).
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        lsu_pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_ar;
        logic        e_lr;
        logic        e_pend;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    wb_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4),
        .DATA_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .lsu_pending (lsu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic e_ar, input logic e_lr, input logic e_pend,
                                input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_pend = e_pend;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //  alu: v  rd  data     lsu: v  rd  data     pre: ar lr pend   post: we addr data
        add(1,  3, 'h11,       0,  0, 'h0,         1, 1, 0,          1,  3, 'h11);
        add(1,  4, 'hA,        1,  5, 'hB,         1, 1, 0,          1,  4, 'hA);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 1,          1,  5, 'hB);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 0,          0,  5, 'hB);
        add(0,  0, 'h0,        1,  0, 'h55,        1, 1, 0,          0,  5, 'hB);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 0,          0,  5, 'hB);
        add(0,  0, 'h0,        1,  7, 'h77,        1, 1, 0,          1,  7, 'h77);
        add(1,  1, 'h100,      1, 10, 'hA0,        1, 1, 0,          1,  1, 'h100);
        add(1,  1, 'h101,      1, 11, 'hA1,        1, 1, 1,          1,  1, 'h101);
        add(1,  1, 'h102,      1, 12, 'hA2,        1, 0, 1,          1,  1, 'h102);
        add(1,  1, 'h103,      0,  0, 'h0,         1, 0, 1,          1,  1, 'h103);
        add(1,  1, 'h104,      0,  0, 'h0,         1, 0, 1,          1,  1, 'h104);
        add(1,  1, 'h105,      0,  0, 'h0,         0, 0, 1,          1, 10, 'hA0);
        add(1,  1, 'h105,      0,  0, 'h0,         1, 1, 1,          1,  1, 'h105);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 1,          1, 11, 'hA1);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 0,          0, 11, 'hA1);
        add(0,  0, 'h0,        1, 13, 'hB0,        1, 1, 0,          1, 13, 'hB0);
        add(1,  2, 'h200,      1, 14, 'hB1,        1, 1, 0,          1,  2, 'h200);
        add(0,  0, 'h0,        1, 15, 'hB2,        1, 1, 1,          1, 14, 'hB1);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 1,          1, 15, 'hB2);
        add(0,  0, 'h0,        0,  0, 'h0,         1, 1, 0,          0, 15, 'hB2);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_en",       32'(wr_en),       32'd0);
        chk("reset_wr_addr",     32'(wr_addr),     32'd0);
        chk("reset_wr_data",     wr_data,          32'd0);
        chk("reset_lsu_ready",   32'(lsu_ready),   32'd0);
        chk("reset_lsu_pending", 32'(lsu_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            #1;
            chk($sformatf("v%0d_alu_ready", i),   32'(alu_ready),   32'(vecs[i].e_ar));
            chk($sformatf("v%0d_lsu_ready", i),   32'(lsu_ready),   32'(vecs[i].e_lr));
            chk($sformatf("v%0d_lsu_pending", i), 32'(lsu_pending), 32'(vecs[i].e_pend));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_en", i),   32'(wr_en),   32'(vecs[i].e_we));
            chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_wa));
            chk($sformatf("v%0d_wr_data", i), wr_data,      vecs[i].e_wd);
        end

        // Reset with two LSU entries queued behind the ALU.
        @(negedge clk);
        drive(1, 1, 'h300, 1, 20, 'hC0);
        @(negedge clk);
        drive(1, 1, 'h301, 1, 21, 'hC1);
        @(posedge clk);
        #1;
        chk("rst_mid_pending_before", 32'(lsu_pending), 32'd1);
        chk("rst_mid_full_before",    32'(lsu_ready),   32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mid_lsu_ready_in_reset", 32'(lsu_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_wr_en",       32'(wr_en),       32'd0);
        chk("rst_mid_wr_addr",     32'(wr_addr),     32'd0);
        chk("rst_mid_lsu_pending", 32'(lsu_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_alu_ready_after", 32'(alu_ready), 32'd1);
        chk("rst_mid_lsu_ready_after", 32'(lsu_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_mid_no_stale_wr_en%0d", k), 32'(wr_en),       32'd0);
            chk($sformatf("rst_mid_no_pending%0d", k),     32'(lsu_pending), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file's single write port.
- Merges results from two producers into one registered (wr_en, wr_addr, wr_data) triple per cycle:
  - ALU: single-cycle results.
  - LSU: load results that arrive at arbitrary times.
- ALU results have priority. LSU results wait in a small FIFO.
- A starvation counter guarantees LSU forward progress.

Parameters:
- DEPTH, 2, LSU result FIFO entries; legal range 1..8.
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be blocked by the ALU before the ALU is throttled; legal range ≥1.
- DATA_W, 32, result data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  LSU result present.
- lsu_ready  out  1  LSU result accepted this cycle when lsu_valid is also high.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  DATA_W  LSU result.
- wr_en  out  1  register-file write enable, registered.
- wr_addr  out  5  register-file write address, registered.
- wr_data  out  DATA_W  register-file write data, registered.
- lsu_pending  out  1  high when the FIFO is non-empty (used by hazard logic).

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-low on rst_n.
- Reset values (while rst_n=0):
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO count=0, starvation counter=0, lsu_pending=0.
  - lsu_ready=0 while reset is asserted.
  - After release: alu_ready=1, lsu_ready=1.
- Handshakes:
  - ALU fire = alu_valid & alu_ready.
  - LSU fire = lsu_valid & lsu_ready.
  - lsu_ready = (count < DEPTH), computed from the registered count only.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- Issue selection, evaluated each cycle, first match wins:
  1. ALU fire → issue the ALU result.
  2. FIFO non-empty → pop the head and issue it.
  3. LSU fire with an empty FIFO → issue the LSU result directly (FIFO bypass).
  4. Otherwise → no issue; wr_en=0 next cycle.
  - An LSU fire not issued directly is pushed to the FIFO tail.
  - Push and pop may occur in the same cycle (non-full case only). Count is unchanged and order is preserved.
- Latency and write suppression:
  - An issued result appears on wr_* exactly 1 cycle after issue.
  - If the issued rd==0, wr_en=0 and wr_addr/wr_data hold their previous values. The slot is still consumed.
- Starvation control (states NORMAL / THROTTLE):
  - NORMAL: counter increments when the FIFO is non-empty and an ALU fire blocks the pop; otherwise it clears.
    - When the counter reaches STARVE_MAX, go to THROTTLE.
  - THROTTLE: alu_ready=0 for exactly one cycle, guaranteeing a FIFO pop.
    - Return to NORMAL and clear the counter.
  - alu_ready=1 in NORMAL.
  - alu_valid asserted during THROTTLE is not accepted. The producer holds the result.
- Ordering:
  - LSU results issue in arrival order.
  - No ordering is enforced between ALU and LSU results. Hazard logic uses lsu_pending.
- FIFO pointers wrap modulo DEPTH. Count saturates logically at DEPTH, and lsu_ready gating prevents overflow.
- Reset mid-operation discards FIFO contents and any pending issue. wr_en=0 the cycle after reset is sampled.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - Adds ports rs1_addr in 5, rs2_addr in 5, fwd1_hit out 1, fwd1_data out DATA_W, fwd2_hit out 1, fwd2_data out DATA_W.
  - fwdN_hit = wr_en & (wr_addr == rsN_addr) & (rsN_addr != 0), combinational.
  - fwdN_data = wr_data.
  - Purpose: covers the cycle in which the register file's combinational read still returns the old value.
- Undefined: these ports do not exist and no comparators are built.

Decomposition:
- Shared package wb_pkg holds:
  - REG_ADDR_W=5, DATA_W default, REG_ZERO=5'd0.
  - Starvation state encoding (ST_NORMAL=1'b0, ST_THROTTLE=1'b1).
  - wb_entry typedef {rd[4:0], data[DATA_W-1:0]}.
- One sub-module, wb_fifo: a DEPTH-entry sync FIFO of wb_entry.
  - Ports: push, pop, full, empty, count, head.
- Selection, starvation FSM and the output register stay in wb_arbiter.

Test Plan:
- Reset, then ALU only: alu_valid=1, rd=3, data=0x11 → next cycle wr_en=1, wr_addr=3, wr_data=0x11; lsu_ready=1; lsu_pending=0.
- Simultaneous fire: ALU rd=4 data=0xA, LSU rd=5 data=0xB → cycle+1 writes r4=0xA. ALU idle next → cycle+2 writes r5=0xB. lsu_pending high for 1 cycle.
- Fill to full: ALU held valid continuously with DEPTH=2, STARVE_MAX=4, two LSU results pushed → lsu_ready=0 after the 2nd push.
  - alu_ready drops for one cycle after 4 blocked cycles, and LSU entries drain in order.
- rd=0 from the LSU via direct bypass → wr_en stays 0, the FIFO stays empty, and the next LSU rd=7 writes normally.
- Assert rst_n=0 with 2 FIFO entries pending → the cycle after, wr_en=0, lsu_pending=0, and no stale write appears after release.
- WB_FWD_EN defined: wr_en=1, wr_addr=9, rs1_addr=9 → fwd1_hit=1 and fwd1_data equals wr_data. With rs2_addr=0 → fwd2_hit=0.
